wb_cmd_master: RTL and testbench
================================

// Module: wb_cmd_master
// PURPOSE
//  Wishbone classic single-transfer bus initiator. Turns one command taken on a valid/ready port into
//  one Wishbone read or write, and returns the result on a valid/ready response port.
//  Bridges LA/GPIO-driven test logic onto the wbs_* slave bus of the user projects.
//  A watchdog ends any cycle that is never acked and flags it as a timeout.
// PARAMETERS
//  TIMEOUT  255  max cycles STB is held waiting for ACK (legal range 1..65535)
// PORTS
//  wb_clk_i      in   1   system clock, all logic on rising edge
//  wb_rst_i      in   1   asynchronous reset, active-high
//  cmd_valid     in   1   command present
//  cmd_ready     out  1   block can accept a command
//  cmd_we        in   1   1=write, 0=read
//  cmd_sel       in   4   byte selects
//  cmd_adr       in   32  byte address
//  cmd_dat       in   32  write data
//  rsp_valid     out  1   response present
//  rsp_ready     in   1   consumer takes response
//  rsp_dat       out  32  read data (0 for writes and timeouts)
//  rsp_timeout   out  1   1=no ACK within TIMEOUT cycles
//  busy          out  1   state != IDLE
//  wbm_cyc_o     out  1   Wishbone CYC
//  wbm_stb_o     out  1   Wishbone STB
//  wbm_we_o      out  1   Wishbone WE
//  wbm_sel_o     out  4   Wishbone SEL
//  wbm_adr_o     out  32  Wishbone ADR
//  wbm_dat_o     out  32  Wishbone write data
//  wbm_ack_i     in   1   Wishbone ACK
//  wbm_dat_i     in   32  Wishbone read data
// BEHAVIOUR
//  - Reset: state=IDLE. All registered outputs are 0: wbm_*, rsp_*, busy, wait counter.
//    cmd_ready is forced to 0 while wb_rst_i=1. Otherwise cmd_ready = (state==IDLE).
//  - FSM states: IDLE, BUS, RESP.
//  - IDLE->BUS on the edge where cmd_valid&cmd_ready:
//      load wbm_we/sel/adr/dat from cmd_*; set cyc=stb=1; clear the counter.
//      CYC/STB go high the cycle after acceptance.
//  - BUS: wbm_we/sel/adr/dat stay stable. ACK is sampled on every edge.
//      ack=1: rsp_dat <= (we ? 0 : wbm_dat_i); rsp_timeout <= 0; rsp_valid <= 1;
//        cyc=stb <= 0; next state RESP.
//      ack=0 and counter==TIMEOUT-1: rsp_dat <= 0; rsp_timeout <= 1; rsp_valid <= 1;
//        cyc=stb <= 0; next state RESP.
//      ack=0 otherwise: counter += 1.
//      STB is high for at most TIMEOUT cycles. If ACK arrives on the final counting cycle, ACK wins.
//  - RESP: rsp_valid stays high and rsp_dat/rsp_timeout stay stable until rsp_ready.
//      On the edge where rsp_valid&rsp_ready: rsp_valid <= 0; next state IDLE.
//  - wbm_we/sel/adr/dat keep their last values outside BUS; only CYC/STB qualify them.
//  - wbm_ack_i outside BUS is ignored: no state change and no response.
//  - cmd_valid outside IDLE is not accepted (cmd_ready=0). The command is held upstream.
//  - cmd_sel=0 is passed through unchanged.
//  - Best case with ACK in the first STB cycle and rsp_ready tied high:
//      accept at edge 0, STB in cycle 1, rsp_valid in cycle 2, cmd_ready back in cycle 3.
//      Throughput is 1 transfer per 3 cycles.
//  - Counter width is $clog2(TIMEOUT+1). The counter never wraps.
//  - Reset asserted mid-transfer: CYC/STB and rsp_valid drop immediately (asynchronous);
//    the pending transfer is discarded.
// TESTING
//  1. Write adr=0x3000_0004 dat=0xDEAD_BEEF sel=0xF, slave acks in 1st cycle
//     -> one STB cycle, we=1, rsp_valid with rsp_dat=0 and timeout=0; cmd_ready back 3 cycles after accept.
//  2. Read adr=0x3000_0000, slave acks after 3 wait cycles returning 0x1234_5678
//     -> STB high 4 cycles, rsp_dat=0x1234_5678, timeout=0.
//  3. TIMEOUT=8, slave never acks
//     -> STB high exactly 8 cycles, then rsp_timeout=1 and rsp_dat=0.
//  4. ACK on the 8th (final) cycle with TIMEOUT=8 -> normal response, timeout=0.
//  5. rsp_ready held low 5 cycles; cmd_valid held high and spurious ACKs injected
//     -> rsp stable, cmd_ready=0, no new CYC, state unchanged until rsp_ready.
//  6. Assert wb_rst_i for 1 cycle mid-BUS
//     -> CYC/STB/rsp_valid drop in the same cycle; after release cmd_ready=1 and a new read completes correctly.

Source files
------------

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone classic single-transfer initiator.
// Accepts one command on a valid/ready port, runs one read or write on the
// Wishbone bus, and returns data plus a timeout flag on a valid/ready
// response port. A watchdog ends any cycle that never sees ACK.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  // Counter value on the last cycle STB may stay high.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [CW-1:0] cnt_r;
  logic          accept_s;
  logic          ack_done_s;
  logic          tmo_done_s;
  logic          rsp_take_s;

  // Ready only when idle and never while reset is asserted.
  assign cmd_ready = ~wb_rst_i & (state_r == IDLE);

  // Next-state decode and per-cycle event strobes.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    ack_done_s   = 1'b0;
    tmo_done_s   = 1'b0;
    rsp_take_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept_s     = 1'b1;
          state_next_s = BUS;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUS: begin
        // ACK takes priority over the watchdog on the final cycle.
        if (wbm_ack_i) begin
          ack_done_s   = 1'b1;
          state_next_s = RESP;
        end else if (cnt_r == CNT_LAST) begin
          tmo_done_s   = 1'b1;
          state_next_s = RESP;
        end else begin
          state_next_s = BUS;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_take_s   = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Bus outputs, wait counter and response registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= 4'h0;
      wbm_adr_o   <= 32'h0000_0000;
      wbm_dat_o   <= 32'h0000_0000;
      rsp_valid   <= 1'b0;
      rsp_dat     <= 32'h0000_0000;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
      cnt_r       <= '0;
    end else begin
      busy <= (state_next_s != IDLE);
      if (accept_s) begin
        wbm_we_o  <= cmd_we;
        wbm_sel_o <= cmd_sel;
        wbm_adr_o <= cmd_adr;
        wbm_dat_o <= cmd_dat;
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        cnt_r     <= '0;
      end else if (ack_done_s) begin
        rsp_dat     <= wbm_we_o ? 32'h0000_0000 : wbm_dat_i;
        rsp_timeout <= 1'b0;
        rsp_valid   <= 1'b1;
        wbm_cyc_o   <= 1'b0;
        wbm_stb_o   <= 1'b0;
      end else if (tmo_done_s) begin
        rsp_dat     <= 32'h0000_0000;
        rsp_timeout <= 1'b1;
        rsp_valid   <= 1'b1;
        wbm_cyc_o   <= 1'b0;
        wbm_stb_o   <= 1'b0;
      end else if (state_r == BUS) begin
        // Still waiting; cnt_r < CNT_LAST here so it cannot wrap.
        cnt_r <= cnt_r + CW'(1);
      end else if (rsp_take_s) begin
        rsp_valid <= 1'b0;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed bench for wb_cmd_master (TIMEOUT=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_wb_cmd_master;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_timeout;
  logic        busy;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  int n_checks = 0;
  int n_fail   = 0;

  wb_cmd_master #(.TIMEOUT(8)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_sel    (cmd_sel),
    .cmd_adr    (cmd_adr),
    .cmd_dat    (cmd_dat),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dat    (rsp_dat),
    .rsp_timeout(rsp_timeout),
    .busy       (busy),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_dat_i  (wbm_dat_i)
  );

  // 10 ns clock.
  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Present one command, play the slave (ACK on STB cycle ack_cycle, 0 = never),
  // and return what was observed once rsp_valid rises. Leaves the response
  // pending; the caller decides when it is taken via rsp_ready.
  task automatic run_transfer(input logic we, input logic [3:0] sel,
                              input logic [31:0] adr, input logic [31:0] dat,
                              input int ack_cycle, input logic [31:0] slave_dat,
                              output int stb_cycles, output logic done,
                              output logic bus_ok, output logic [31:0] r_dat,
                              output logic r_to);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_sel   = sel;
    cmd_adr   = adr;
    cmd_dat   = dat;
    stb_cycles = 0;
    done       = 1'b0;
    bus_ok     = 1'b1;
    r_dat      = 32'h0;
    r_to       = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge wb_clk_i);
      cmd_valid = 1'b0;
      if (wbm_stb_o) begin
        stb_cycles++;
        if (wbm_cyc_o !== 1'b1 || wbm_we_o !== we || wbm_sel_o !== sel ||
            wbm_adr_o !== adr || wbm_dat_o !== dat || cmd_ready !== 1'b0 ||
            busy !== 1'b1 || rsp_valid !== 1'b0)
          bus_ok = 1'b0;
        wbm_dat_i = slave_dat;
        wbm_ack_i = (stb_cycles == ack_cycle);
      end else begin
        wbm_ack_i = 1'b0;
        if (rsp_valid) begin
          done  = 1'b1;
          r_dat = rsp_dat;
          r_to  = rsp_timeout;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    wb_rst_i  = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_sel   = 4'h0;
    cmd_adr   = 32'h0;
    cmd_dat   = 32'h0;
    rsp_ready = 1'b1;
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    cmd_valid = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    n_checks++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_timeout, busy, cmd_ready} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got cyc=%b stb=%b we=%b rv=%b to=%b busy=%b rdy=%b, want all 0",
               wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_timeout, busy, cmd_ready);
    end
    n_checks++;
    if ({wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_dat} !== 100'h0) begin
      n_fail++;
      $display("FAIL reset_data: got sel=%h adr=%h dat=%h rdat=%h, want 0",
               wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_dat);
    end
    cmd_valid = 1'b0;
    wb_rst_i  = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write_fast();
    int n; logic done, ok, to; logic [31:0] d;
    run_transfer(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFF, n, done, ok, d, to);
    n_checks++;
    if (done !== 1'b1 || n != 1 || ok !== 1'b1 || d !== 32'h0 || to !== 1'b0) begin
      n_fail++;
      $display("FAIL write_fast: got done=%b stb=%0d bus_ok=%b dat=%h to=%b, want 1 1 1 0 0",
               done, n, ok, d, to);
    end
    @(negedge wb_clk_i);
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL write_fast_ready: got rdy=%b rv=%b busy=%b, want 1 0 0", cmd_ready, rsp_valid, busy);
    end
  endtask

  task automatic test_read_wait();
    int n; logic done, ok, to; logic [31:0] d;
    run_transfer(1'b0, 4'hF, 32'h3000_0000, 32'h0, 4, 32'h1234_5678, n, done, ok, d, to);
    n_checks++;
    if (done !== 1'b1 || n != 4 || ok !== 1'b1 || d !== 32'h1234_5678 || to !== 1'b0) begin
      n_fail++;
      $display("FAIL read_wait: got done=%b stb=%0d bus_ok=%b dat=%h to=%b, want 1 4 1 12345678 0",
               done, n, ok, d, to);
    end
    @(negedge wb_clk_i);
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_wait_ready: got rdy=%b rv=%b, want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_sel_zero();
    int n; logic done, ok, to; logic [31:0] d;
    run_transfer(1'b1, 4'h0, 32'h3000_0010, 32'h0000_00A5, 2, 32'h7777_7777, n, done, ok, d, to);
    n_checks++;
    if (done !== 1'b1 || n != 2 || ok !== 1'b1 || d !== 32'h0 || to !== 1'b0) begin
      n_fail++;
      $display("FAIL sel_zero: got done=%b stb=%0d bus_ok=%b dat=%h to=%b, want 1 2 1 0 0",
               done, n, ok, d, to);
    end
    @(negedge wb_clk_i);
  endtask

  task automatic test_timeout();
    int n; logic done, ok, to; logic [31:0] d;
    run_transfer(1'b0, 4'hF, 32'h3000_0008, 32'h0, 0, 32'h5555_AAAA, n, done, ok, d, to);
    n_checks++;
    if (done !== 1'b1 || n != 8 || ok !== 1'b1 || d !== 32'h0 || to !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: got done=%b stb=%0d bus_ok=%b dat=%h to=%b, want 1 8 1 0 1",
               done, n, ok, d, to);
    end
    @(negedge wb_clk_i);
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_ready: got rdy=%b rv=%b, want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_ack_last_cycle();
    int n; logic done, ok, to; logic [31:0] d;
    run_transfer(1'b0, 4'hF, 32'h3000_000C, 32'h0, 8, 32'hCAFE_F00D, n, done, ok, d, to);
    n_checks++;
    if (done !== 1'b1 || n != 8 || ok !== 1'b1 || d !== 32'hCAFE_F00D || to !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_last: got done=%b stb=%0d bus_ok=%b dat=%h to=%b, want 1 8 1 cafef00d 0",
               done, n, ok, d, to);
    end
    @(negedge wb_clk_i);
  endtask

  task automatic test_back_pressure();
    int n; logic done, ok, to; logic [31:0] d;
    rsp_ready = 1'b0;
    run_transfer(1'b0, 4'hF, 32'h3000_0020, 32'h0, 1, 32'h8765_4321, n, done, ok, d, to);
    n_checks++;
    if (done !== 1'b1 || n != 1 || d !== 32'h8765_4321 || to !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_first: got done=%b stb=%0d dat=%h to=%b, want 1 1 87654321 0", done, n, d, to);
    end
    // Next command held upstream while spurious ACKs arrive.
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_sel   = 4'h3;
    cmd_adr   = 32'h3000_0024;
    cmd_dat   = 32'h1111_2222;
    wbm_ack_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge wb_clk_i);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_dat !== 32'h8765_4321 || rsp_timeout !== 1'b0 ||
          cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got rv=%b dat=%h to=%b rdy=%b cyc=%b stb=%b busy=%b, want 1 87654321 0 0 0 0 1",
                 i, rsp_valid, rsp_dat, rsp_timeout, cmd_ready, wbm_cyc_o, wbm_stb_o, busy);
      end
    end
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got rv=%b rdy=%b cyc=%b, want 0 1 0", rsp_valid, cmd_ready, wbm_cyc_o);
    end
    run_transfer(1'b1, 4'h3, 32'h3000_0024, 32'h1111_2222, 1, 32'h9999_9999, n, done, ok, d, to);
    n_checks++;
    if (done !== 1'b1 || n != 1 || ok !== 1'b1 || d !== 32'h0 || to !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_held_cmd: got done=%b stb=%0d bus_ok=%b dat=%h to=%b, want 1 1 1 0 0",
               done, n, ok, d, to);
    end
    @(negedge wb_clk_i);
    // ACK while idle must be ignored.
    wbm_ack_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ack: got rv=%b cyc=%b busy=%b rdy=%b, want 0 0 0 1",
               rsp_valid, wbm_cyc_o, busy, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_bus();
    int n; logic done, ok, to; logic [31:0] d;
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_sel   = 4'hF;
    cmd_adr   = 32'h3000_0030;
    cmd_dat   = 32'h0;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    n_checks++;
    if (wbm_stb_o !== 1'b1 || wbm_cyc_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got cyc=%b stb=%b, want 1 1", wbm_cyc_o, wbm_stb_o);
    end
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    #1;
    n_checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
        cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_drop: got cyc=%b stb=%b rv=%b busy=%b rdy=%b, want all 0",
               wbm_cyc_o, wbm_stb_o, rsp_valid, busy, cmd_ready);
    end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_release: got rdy=%b rv=%b, want 1 0", cmd_ready, rsp_valid);
    end
    run_transfer(1'b0, 4'hF, 32'h3000_0034, 32'h0, 2, 32'h0BAD_CAFE, n, done, ok, d, to);
    n_checks++;
    if (done !== 1'b1 || n != 2 || ok !== 1'b1 || d !== 32'h0BAD_CAFE || to !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_after: got done=%b stb=%0d bus_ok=%b dat=%h to=%b, want 1 2 1 0badcafe 0",
               done, n, ok, d, to);
    end
    @(negedge wb_clk_i);
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_write_fast();
    test_read_wait();
    test_sel_zero();
    test_timeout();
    test_ack_last_cycle();
    test_back_pressure();
    test_reset_mid_bus();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
